// File: rtl/eight_bit_piso_transmitter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : eight_bit_piso_transmitter_if                              |
// | Description : Load-side handshake and serial-side signal bundle for the  |
// |               parallel-in/serial-out transmitter.                        |
// |   in         parallel word offered by the producer                       |
// |   load_valid producer has a word on in                                   |
// |   load_ready transmitter accepts a word this cycle                       |
// |   ser_out    serial data bit                                             |
// |   ser_valid  ser_out carries a valid bit                                 |
// |   last       final bit of a frame                                        |
// |   busy       frame in progress                                           |
// |   slave  modport : transmitter side                                      |
// |   master modport : producer / consumer side (testbench, parent block)    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface eight_bit_piso_transmitter_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in;
   logic             load_valid;
   logic             load_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             last;
   logic             busy;

   modport slave (
      input  in,
      input  load_valid,
      output load_ready,
      output ser_out,
      output ser_valid,
      output last,
      output busy
   );

   modport master (
      output in,
      output load_valid,
      input  load_ready,
      input  ser_out,
      input  ser_valid,
      input  last,
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/eight_bit_piso_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : eight_bit_piso_transmitter                                 |
// | Description : Parallel-in/serial-out transmitter. Accepts a WIDTH-bit    |
// |               word over a valid/ready handshake and shifts it out one    |
// |               bit per clock, flagging the final bit of each frame with   |
// |               last. Frames may be chained back-to-back without gaps.     |
// | Parameters  : WIDTH     data word width (>= 2)                           |
// |               MSB_FIRST 0: bit 0 first, 1: bit WIDTH-1 first             |
// | Macro       : PIPO_TX_PARITY_EN - when defined, an even-parity bit is    |
// |               appended after the data bits and carries last.             |
// | Ports       : clk  rising-edge clock                                     |
// |               rst  asynchronous reset, active low                        |
// |               bus  slave modport: in, load_valid -> load_ready,          |
// |                    ser_out, ser_valid, last, busy                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module eight_bit_piso_transmitter #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  wire                            clk,
   input  wire                            rst,
   eight_bit_piso_transmitter_if.slave    bus
);

`ifdef PIPO_TX_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
`ifdef PIPO_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             last_bit;
   logic             load_ready;
   logic             accept;

   // The last-bit cycle is the one where the final frame bit sits on the
   // output registers; a new word may be taken in that same cycle.
   assign last_bit   = (state_q == S_SHIFT) && (cnt_q == CNT_W'(FRAME - 1));
   assign load_ready = (state_q == S_IDLE) || last_bit;
   assign accept     = bus.load_valid && load_ready;

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      ser_out_d   = 1'b0;
      ser_valid_d = 1'b0;
      last_d      = 1'b0;
      busy_d      = 1'b0;
`ifdef PIPO_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      if (accept) begin
         // The first bit goes straight to the output register on the
         // accepting edge; the shift register keeps the remaining bits.
         state_d     = S_SHIFT;
         cnt_d       = '0;
         ser_valid_d = 1'b1;
         busy_d      = 1'b1;
         if (MSB_FIRST) begin
            ser_out_d = bus.in[WIDTH-1];
            shreg_d   = bus.in << 1;
         end else begin
            ser_out_d = bus.in[0];
            shreg_d   = bus.in >> 1;
         end
`ifdef PIPO_TX_PARITY_EN
         parity_d    = ^bus.in;
`endif
      end else if (state_q == S_SHIFT) begin
         if (last_bit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d       = cnt_q + CNT_W'(1);
            ser_valid_d = 1'b1;
            busy_d      = 1'b1;
            last_d      = (cnt_q == CNT_W'(FRAME - 2));
`ifdef PIPO_TX_PARITY_EN
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               // All data bits have gone; the parity bit closes the frame.
               ser_out_d = parity_q;
            end else
`endif
            if (MSB_FIRST) begin
               ser_out_d = shreg_q[WIDTH-1];
               shreg_d   = shreg_q << 1;
            end else begin
               ser_out_d = shreg_q[0];
               shreg_d   = shreg_q >> 1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
`ifdef PIPO_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
`ifdef PIPO_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign bus.load_ready = load_ready;
   assign bus.ser_out    = ser_out_q;
   assign bus.ser_valid  = ser_valid_q;
   assign bus.last       = last_q;
   assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_eight_bit_piso_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_eight_bit_piso_transmitter                              |
// | Description : Self-checking bench. Drives an LSB-first and an MSB-first  |
// |               transmitter with identical stimulus; expected serial bits  |
// |               are queued per instance when a word is accepted and popped |
// |               as bits appear.                                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_eight_bit_piso_transmitter;

   localparam int WIDTH = 8;
`ifdef PIPO_TX_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] drv_in = '0;
   logic             drv_valid = 1'b0;
   logic             cur_par = 1'b0;

   always #5 clk = ~clk;

   eight_bit_piso_transmitter_if #(.WIDTH(WIDTH)) bus_l ();
   eight_bit_piso_transmitter_if #(.WIDTH(WIDTH)) bus_m ();

   assign bus_l.in         = drv_in;
   assign bus_l.load_valid = drv_valid;
   assign bus_m.in         = drv_in;
   assign bus_m.load_valid = drv_valid;

   eight_bit_piso_transmitter #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
      .clk (clk),
      .rst (rst),
      .bus (bus_l.slave)
   );

   eight_bit_piso_transmitter #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
      .clk (clk),
      .rst (rst),
      .bus (bus_m.slave)
   );

   typedef struct {
      logic [WIDTH-1:0] word;
      bit               chain;   // accept during the previous frame's last bit
      logic             par;     // expected even-parity bit
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   int         mdl_pos = -1;     // index of the bit on the outputs, -1 idle
   logic [1:0] q_l[$];           // {ser_out, last}
   logic [1:0] q_m[$];
   vec_t       vecs[7];

   function automatic bit exp_ready();
      return (mdl_pos < 0) || (mdl_pos == FRAME - 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout/underflow, expected event (t=%0t)", name, $time);
   endtask

   task automatic push_frame(input logic [WIDTH-1:0] w, input logic p);
      for (int i = 0; i < WIDTH; i++) begin
         q_l.push_back({w[i], (i == FRAME - 1)});
         q_m.push_back({w[WIDTH-1-i], (i == FRAME - 1)});
      end
`ifdef PIPO_TX_PARITY_EN
      q_l.push_back({p, 1'b1});
      q_m.push_back({p, 1'b1});
`else
      if (p === 1'bx) $display("note: unknown parity");
`endif
   endtask

   task automatic monitor();
      logic [1:0] e;
      logic       v;
      v = (mdl_pos >= 0);
      check("l.load_ready", bus_l.load_ready, exp_ready());
      check("m.load_ready", bus_m.load_ready, exp_ready());
      check("l.ser_valid", bus_l.ser_valid, v);
      check("m.ser_valid", bus_m.ser_valid, v);
      check("l.busy", bus_l.busy, v);
      check("m.busy", bus_m.busy, v);
      if (v) begin
         if (q_l.size() == 0) fail("l.scoreboard");
         else begin
            e = q_l.pop_front();
            check("l.ser_out", bus_l.ser_out, e[1]);
            check("l.last", bus_l.last, e[0]);
         end
         if (q_m.size() == 0) fail("m.scoreboard");
         else begin
            e = q_m.pop_front();
            check("m.ser_out", bus_m.ser_out, e[1]);
            check("m.last", bus_m.last, e[0]);
         end
      end else begin
         check("l.idle_ser_out", bus_l.ser_out, 0);
         check("l.idle_last", bus_l.last, 0);
         check("m.idle_ser_out", bus_m.ser_out, 0);
         check("m.idle_last", bus_m.last, 0);
      end
   endtask

   // Advance one clock: inputs are stable from the previous falling edge,
   // outputs are checked on the next falling edge.
   task automatic tick();
      bit acc;
      acc = rst && drv_valid && exp_ready();
      if (acc) push_frame(drv_in, cur_par);
      @(posedge clk);
      if (!rst)              mdl_pos = -1;
      else if (acc)          mdl_pos = 0;
      else if (mdl_pos >= 0) mdl_pos = (mdl_pos == FRAME - 1) ? -1 : mdl_pos + 1;
      @(negedge clk);
      monitor();
   endtask

   task automatic apply(input logic [WIDTH-1:0] w, input logic p);
      int g;
      g = 0;
      drv_in    = w;
      drv_valid = 1'b1;
      cur_par   = p;
      while (!exp_ready() && g < 20) begin
         tick();
         g++;
      end
      if (g >= 20) fail("accept_timeout");
      tick();
      drv_valid = 1'b0;
      drv_in    = ~w;   // must not disturb the held word
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (mdl_pos >= 0 && g < 20) begin
         tick();
         g++;
      end
      if (g >= 20) fail("drain_timeout");
      tick();
   endtask

   task automatic wait_pos(input int pos);
      int g;
      g = 0;
      while (mdl_pos != pos && g < 20) begin
         tick();
         g++;
      end
      if (g >= 20) fail("wait_pos_timeout");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".l.ser_out"},    bus_l.ser_out, 0);
      check({tag, ".l.ser_valid"},  bus_l.ser_valid, 0);
      check({tag, ".l.last"},       bus_l.last, 0);
      check({tag, ".l.busy"},       bus_l.busy, 0);
      check({tag, ".l.load_ready"}, bus_l.load_ready, 1);
      check({tag, ".m.ser_out"},    bus_m.ser_out, 0);
      check({tag, ".m.ser_valid"},  bus_m.ser_valid, 0);
      check({tag, ".m.last"},       bus_m.last, 0);
      check({tag, ".m.busy"},       bus_m.busy, 0);
      check({tag, ".m.load_ready"}, bus_m.load_ready, 1);
   endtask

   initial begin
      vecs[0] = '{word: 8'h01, chain: 1'b0, par: 1'b1};
      vecs[1] = '{word: 8'hFF, chain: 1'b0, par: 1'b0};
      vecs[2] = '{word: 8'h00, chain: 1'b1, par: 1'b0};
      vecs[3] = '{word: 8'h55, chain: 1'b0, par: 1'b0};
      vecs[4] = '{word: 8'h07, chain: 1'b0, par: 1'b1};
      vecs[5] = '{word: 8'h03, chain: 1'b0, par: 1'b0};
      vecs[6] = '{word: 8'h81, chain: 1'b1, par: 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      tick();

      // Table-driven frames; chained entries are taken in the last-bit cycle
      for (int i = 0; i < 7; i++) begin
         apply(vecs[i].word, vecs[i].par);
         if (!(i + 1 < 7 && vecs[i+1].chain)) drain();
      end

      // A load attempt in the middle of a frame is ignored
      apply(8'hAA, 1'b0);
      wait_pos(2);
      drv_in    = 8'h55;
      drv_valid = 1'b1;
      check("ignore.load_ready", bus_l.load_ready, 0);
      tick();
      drv_valid = 1'b0;
      drain();

      // Asynchronous reset mid-frame, then a clean frame
      apply(8'hC3, 1'b0);
      wait_pos(2);
      #2 rst = 1'b0;
      #1 check_reset_outputs("async_rst");
      q_l.delete();
      q_m.delete();
      mdl_pos   = -1;
      drv_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      apply(8'h81, 1'b0);
      drain();

      check("l.scoreboard_left", q_l.size(), 0);
      check("m.scoreboard_left", q_m.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
